// File: rtl/sevseg_mux_ctrl.sv
// rtl/sevseg_mux_ctrl.sv - Wishbone eight-digit seven-segment mux controller.
// Optional leading-zero blanking: SEVSEG_LZ_BLANK_EN.
module sevseg_mux_ctrl #(
    parameter logic [15:0] PRESCALE_RST = 16'd50000,
    parameter logic [7:0]  ENABLE_RST   = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [7:0]  AN,
    output logic [6:0]  seg
);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    logic [31:0] digits;
    logic [7:0]  enable;
    logic [15:0] prescale;
    logic [15:0] cnt;
    logic [2:0]  idx;
    state_t      state;

    logic        access;
    logic        tick;
    logic [31:0] rd_data;
    logic [3:0]  nibble;
    logic [7:0]  digit_on;

    wire unused_adr = &{1'b0, wb_adr_i[1:0]};

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: hex_decode = 7'h01;
            4'h1: hex_decode = 7'h4F;
            4'h2: hex_decode = 7'h12;
            4'h3: hex_decode = 7'h06;
            4'h4: hex_decode = 7'h4C;
            4'h5: hex_decode = 7'h24;
            4'h6: hex_decode = 7'h20;
            4'h7: hex_decode = 7'h0F;
            4'h8: hex_decode = 7'h00;
            4'h9: hex_decode = 7'h04;
            4'hA: hex_decode = 7'h08;
            4'hB: hex_decode = 7'h60;
            4'hC: hex_decode = 7'h31;
            4'hD: hex_decode = 7'h42;
            4'hE: hex_decode = 7'h30;
            default: hex_decode = 7'h38;
        endcase
    endfunction

    assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign tick   = (cnt == 16'd0);
    assign nibble = digits[{idx, 2'b00} +: 4];

`ifdef SEVSEG_LZ_BLANK_EN
    logic [7:0] lz_keep;

    // Digit n stays lit only while some nibble at or above n is non-zero.
    always_comb begin
        lz_keep = 8'h01;
        for (int n = 1; n < 8; n++) begin
            lz_keep[n] = |(digits >> (4 * n));
        end
    end

    assign digit_on = enable & lz_keep;
`else
    assign digit_on = enable;
`endif

    always_comb begin
        rd_data = 32'h0;
        case (wb_adr_i[3:2])
            2'd0:    rd_data = digits;
            2'd1:    rd_data = {24'h0, enable};
            2'd2:    rd_data = {16'h0, prescale};
            default: rd_data = {29'h0, idx};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'h0;
            digits   <= 32'h0;
            enable   <= ENABLE_RST;
            prescale <= PRESCALE_RST;
        end else begin
            wb_ack_o <= access;
            if (access) begin
                wb_dat_o <= rd_data;
                if (wb_we_i) begin
                    case (wb_adr_i[3:2])
                        2'd0: begin
                            for (int b = 0; b < 4; b++) begin
                                if (wb_sel_i[b]) digits[8*b +: 8] <= wb_dat_i[8*b +: 8];
                            end
                        end
                        2'd1: if (wb_sel_i[0]) enable <= wb_dat_i[7:0];
                        2'd2: begin
                            if (wb_sel_i[0]) prescale[7:0]  <= wb_dat_i[7:0];
                            if (wb_sel_i[1]) prescale[15:8] <= wb_dat_i[15:8];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Pins follow the state register by one cycle, so every tick yields one dark cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= PRESCALE_RST;
            idx   <= 3'd0;
            state <= ST_BLANK;
            AN    <= 8'hFF;
            seg   <= 7'h7F;
        end else begin
            if (tick) begin
                cnt   <= prescale;
                idx   <= idx + 3'd1;
                state <= ST_BLANK;
            end else begin
                cnt   <= cnt - 16'd1;
                state <= ST_SHOW;
            end
            if (state == ST_SHOW) begin
                AN  <= digit_on[idx] ? ~(8'b1 << idx) : 8'hFF;
                seg <= hex_decode(nibble);
            end else begin
                AN  <= 8'hFF;
                seg <= 7'h7F;
            end
        end
    end

endmodule

// File: tb/tb_sevseg_mux_ctrl.sv
// tb/tb_sevseg_mux_ctrl.sv - directed self-checking bench for sevseg_mux_ctrl.
module tb_sevseg_mux_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wb_adr_i = 4'h0;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [7:0]  AN;
    logic [6:0]  seg;

    int checks = 0;
    int failures = 0;

    logic [6:0] seq_exp [8] = '{7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00};
    logic [6:0] lz_seg  [4] = '{7'h4C, 7'h06, 7'h12, 7'h4F};

    sevseg_mux_ctrl #(.PRESCALE_RST(16'd3), .ENABLE_RST(8'hFF)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .AN(AN), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
        wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        step(1);
        check("wr_ack", {31'h0, wb_ack_o}, 32'h1);
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step(1);
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
        wb_adr_i = a; wb_sel_i = 4'h0;
        wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        step(1);
        check("rd_ack", {31'h0, wb_ack_o}, 32'h1);
        d = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  an_exp;
        logic [7:0]  saw_low;
        int          guard;
        int          acks;

        // Reset state, then the free-running frame with PRESCALE=3 and DIGITS=0.
        step(3);
        check("rst_an", AN, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_ack", wb_ack_o, 1'b0);
        check("rst_dat", wb_dat_o, 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            step(1);
            if ((k - 1) % 4 == 0) begin
                check("frame_blank_an", AN, 8'hFF);
                check("frame_blank_seg", seg, 7'h7F);
            end else begin
                an_exp = ~(8'b1 << (((k - 2) / 4) % 8));
                check("frame_show_an", AN, an_exp);
                check("frame_show_seg", seg, 7'h01);
            end
        end

        // Full hex sequence with PRESCALE=1 (one lit cycle, one dark cycle per slot).
        wb_write(4'h8, 32'h1, 4'hF);
        wb_write(4'h0, 32'h89ABCDEF, 4'hF);
        step(8);
        guard = 0;
        while (AN !== 8'hFE && guard < 200) begin step(1); guard++; end
        check("sync_digit0", AN, 8'hFE);
        for (int i = 0; i < 8; i++) begin
            an_exp = ~(8'b1 << i);
            check("hex_an", AN, an_exp);
            check("hex_seg", seg, seq_exp[i]);
            step(1);
            check("hex_gap_an", AN, 8'hFF);
            check("hex_gap_seg", seg, 7'h7F);
            step(1);
        end

        // ENABLE mask.
        wb_write(4'h4, 32'h05, 4'h1);
        wb_read(4'h4, d);
        check("enable_rd", d, 32'h5);
        step(4);
        saw_low = 8'h00;
        for (int i = 0; i < 32; i++) begin
            check("enable_mask_an", AN | 8'h05, 8'hFF);
            saw_low = saw_low | ~AN;
            step(1);
        end
        check("enable_saw_low", saw_low, 8'h05);
        wb_write(4'h4, 32'hFF, 4'h1);

        // Leading-zero blanking (or its absence in the default build).
        wb_write(4'h0, 32'h00001234, 4'hF);
        step(4);
        saw_low = 8'h00;
        for (int i = 0; i < 32; i++) begin
            saw_low = saw_low | ~AN;
            for (int j = 0; j < 4; j++) begin
                an_exp = ~(8'b1 << j);
                if (AN == an_exp) check("lz_seg", seg, lz_seg[j]);
            end
            step(1);
        end
`ifdef SEVSEG_LZ_BLANK_EN
        check("lz_1234_lit", saw_low, 8'h0F);
`else
        check("lz_1234_lit", saw_low, 8'hFF);
`endif
        wb_write(4'h0, 32'h0, 4'hF);
        step(4);
        saw_low = 8'h00;
        for (int i = 0; i < 32; i++) begin
            saw_low = saw_low | ~AN;
            if (AN == 8'hFE) check("lz_zero_seg", seg, 7'h01);
            step(1);
        end
`ifdef SEVSEG_LZ_BLANK_EN
        check("lz_zero_lit", saw_low, 8'h01);
`else
        check("lz_zero_lit", saw_low, 8'hFF);
`endif

        // PRESCALE=0: a tick every cycle leaves no lit cycles.
        wb_write(4'h8, 32'h0, 4'hF);
        step(4);
        for (int i = 0; i < 16; i++) begin
            check("p0_an", AN, 8'hFF);
            check("p0_seg", seg, 7'h7F);
            step(1);
        end

        // Byte lanes, ignored bytes, zero-extended reads.
        wb_write(4'h0, 32'h0, 4'hF);
        wb_write(4'h0, 32'h00AB0000, 4'b0100);
        wb_read(4'h0, d);
        check("byte_lane2", d, 32'h00AB0000);
        wb_write(4'h0, 32'h12345678, 4'b0001);
        wb_read(4'h0, d);
        check("byte_lane0", d, 32'h00AB0078);
        wb_write(4'h4, 32'h00000000, 4'b1110);
        wb_read(4'h4, d);
        check("enable_upper_ignored", d, 32'hFF);
        wb_write(4'h8, 32'hFFFF0001, 4'hF);
        wb_read(4'h8, d);
        check("prescale_rd", d, 32'h1);
        wb_write(4'hC, 32'hFFFFFFFF, 4'hF);
        wb_read(4'hC, d);
        check("status_upper_zero", {3'b000, d[31:3]}, 32'h0);

        // Held strobe for 6 cycles gives alternate-cycle acks.
        wb_adr_i = 4'h0; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (wb_ack_o) acks++;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check("held_stb_acks", acks, 32'd3);
        step(1);

        // Reset while a digit is lit, then STATUS tracks idx.
        guard = 0;
        while (AN === 8'hFF && guard < 50) begin step(1); guard++; end
        check("pre_reset_lit", {31'h0, AN !== 8'hFF}, 32'h1);
        rst = 1'b1;
        step(1);
        check("midrst_an", AN, 8'hFF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_ack", wb_ack_o, 1'b0);
        check("midrst_dat", wb_dat_o, 32'h0);
        rst = 1'b0;
        wb_read(4'hC, d);
        check("status_idx0", d, 32'h0);
        step(3);
        wb_read(4'hC, d);
        check("status_idx1", d, 32'h1);
        wb_read(4'h8, d);
        check("prescale_after_rst", d, 32'h3);
        wb_read(4'h0, d);
        check("digits_after_rst", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
